fft_butterfly_scheduler: RTL and testbench

// - Sequences the radix-2 butterfly unit (butterfly_wrapper) through a full in-place DIT FFT of 2^N_LOG2 points.
// - Per operation, issues sample-memory addresses for A/B (results X->addr_a, Y->addr_b) and a twiddle-ROM index for W.
// - Input data is expected in bit-reversed order; output is natural order.
// - Sits between the top-level FFT control (start/done) and the memory/butterfly datapath (valid/ready).

---
 rtl/fft_butterfly_scheduler.sv | 146 ++++++++++++++
 tb/tb_fft_butterfly_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_butterfly_scheduler.sv
// Radix-2 DIT FFT butterfly address/twiddle sequencer, one op per cycle.
// Define FFT_SCHED_STAGE_FLUSH_EN to drain BF_LATENCY cycles between stages.
module fft_butterfly_scheduler #(
  parameter int N_LOG2     = 5,
  parameter int BF_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [N_LOG2-1:0] op_addr_a,
  output logic [N_LOG2-1:0] op_addr_b,
  output logic [N_LOG2-2:0] op_tw_addr,
  output logic [3:0]        op_stage,
  output logic              op_last
);

  localparam int KW = N_LOG2 - 1;
  localparam logic [3:0]        SMAX = 4'(N_LOG2 - 1);
  localparam logic [KW-1:0]     KMAX = '1;
  localparam logic [N_LOG2-1:0] ONE  = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_t;

  state_t         st, st_n;
  logic [3:0]     s, s_n;
  logic [KW-1:0]  k, k_n;

`ifdef FFT_SCHED_STAGE_FLUSH_EN
  logic [7:0] fc, fc_n;
  logic       fin, fin_n;
`else
  logic [7:0] unused_bf;
  assign unused_bf = 8'(BF_LATENCY);
`endif

  always_comb begin
    st_n = st;
    s_n  = s;
    k_n  = k;
`ifdef FFT_SCHED_STAGE_FLUSH_EN
    fc_n  = fc;
    fin_n = fin;
`endif
    unique case (st)
      IDLE: begin
        if (start) begin
          st_n = ISSUE;
          s_n  = '0;
          k_n  = '0;
        end
      end
      ISSUE: begin
        if (op_ready) begin
          if (k != KMAX) begin
            k_n = k + KW'(1);
          end else begin
            k_n = '0;
`ifdef FFT_SCHED_STAGE_FLUSH_EN
            st_n  = FLUSH;
            fc_n  = '0;
            fin_n = (s == SMAX);
            s_n   = (s == SMAX) ? 4'd0 : s + 4'd1;
`else
            if (s != SMAX) begin
              s_n = s + 4'd1;
            end else begin
              s_n  = '0;
              st_n = DONE;
            end
`endif
          end
        end
      end
      FLUSH: begin
`ifdef FFT_SCHED_STAGE_FLUSH_EN
        if (fc == 8'(BF_LATENCY - 1))
          st_n = fin ? DONE : ISSUE;
        else
          fc_n = fc + 8'd1;
`else
        st_n = IDLE;
`endif
      end
      DONE:    st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  // Payload is precomputed from the next counters so outputs stay registered.
  logic [N_LOG2-1:0] kx, hx, jx, a_n, b_n;
  logic [KW-1:0]     tw_n;

  always_comb begin
    kx   = N_LOG2'(k_n);
    hx   = ONE << s_n;
    jx   = kx & (hx - ONE);
    a_n  = ((kx >> s_n) << (s_n + 4'd1)) | jx;
    b_n  = a_n + hx;
    tw_n = KW'(jx << (SMAX - s_n));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      s          <= '0;
      k          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      op_valid   <= 1'b0;
      op_addr_a  <= '0;
      op_addr_b  <= '0;
      op_tw_addr <= '0;
      op_stage   <= '0;
      op_last    <= 1'b0;
    end else begin
      st         <= st_n;
      s          <= s_n;
      k          <= k_n;
      busy       <= (st_n == ISSUE) || (st_n == FLUSH);
      done       <= (st_n == DONE);
      op_valid   <= (st_n == ISSUE);
      op_addr_a  <= (st_n == ISSUE) ? a_n : '0;
      op_addr_b  <= (st_n == ISSUE) ? b_n : '0;
      op_tw_addr <= (st_n == ISSUE) ? tw_n : '0;
      op_stage   <= (st_n == ISSUE) ? s_n : '0;
      op_last    <= (st_n == ISSUE) && (s_n == SMAX) && (k_n == KMAX);
    end
  end

`ifdef FFT_SCHED_STAGE_FLUSH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fc  <= '0;
      fin <= 1'b0;
    end else begin
      fc  <= fc_n;
      fin <= fin_n;
    end
  end
`endif

endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// Scoreboard bench for fft_butterfly_scheduler, N_LOG2=3.
// Reference op list built from FFT group/offset arithmetic.
module tb_fft_butterfly_scheduler;

  localparam int NL   = 3;
  localparam int BFL  = 2;
  localparam int N    = 1 << NL;
  localparam int NOPS = NL * N / 2;
`ifdef FFT_SCHED_STAGE_FLUSH_EN
  localparam int GAP = BFL;
`else
  localparam int GAP = 0;
`endif
  localparam int DLAT = GAP + 1;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, op_valid, op_ready, op_last;
  logic [NL-1:0] op_addr_a, op_addr_b;
  logic [NL-2:0] op_tw_addr;
  logic [3:0]    op_stage;

  fft_butterfly_scheduler #(.N_LOG2(NL), .BF_LATENCY(BFL)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_addr_a(op_addr_a), .op_addr_b(op_addr_b),
    .op_tw_addr(op_tw_addr), .op_stage(op_stage), .op_last(op_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a; int b; int tw; int st; bit last; bit send;
  } op_t;

  op_t q[$];
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Stage st has N/(2*half) groups, each of half butterflies spaced half apart.
  task automatic gen_ops();
    op_t o;
    for (int st = 0; st < NL; st++) begin
      int half = 1 << st;
      int ng   = N / (2 * half);
      for (int g = 0; g < ng; g++) begin
        for (int j = 0; j < half; j++) begin
          o.a    = g * 2 * half + j;
          o.b    = o.a + half;
          o.tw   = j * ng;
          o.st   = st;
          o.send = (g == ng - 1) && (j == half - 1);
          o.last = o.send && (st == NL - 1);
          q.push_back(o);
        end
      end
    end
  endtask

  int  dcnt = -1;
  int  hs = 0;
  int  gap = 0;
  bit  armed = 0;
  bit  done_prev = 0;

  always @(negedge clk) begin
    op_t e;
    if (rst) begin
      q.delete();
      dcnt = -1; hs = 0; armed = 0; done_prev = 0;
    end else begin
      if (done_prev) chk("done_pulse_width", int'(done), 0);
      if (dcnt >= 0) dcnt++;
      if (op_valid) begin
        if (armed) begin
          chk("stage_gap", gap, GAP);
          armed = 0;
        end
        chk("busy_with_valid", int'(busy), 1);
        if (q.size() == 0) begin
          chk("unexpected_op", 0, 1);
        end else begin
          e = q[0];
          chk("addr_a", int'(op_addr_a), e.a);
          chk("addr_b", int'(op_addr_b), e.b);
          chk("tw", int'(op_tw_addr), e.tw);
          chk("stage", int'(op_stage), e.st);
          chk("last", int'(op_last), int'(e.last));
          if (op_ready) begin
            void'(q.pop_front());
            hs++;
            if (e.last) dcnt = 0;
            else if (e.send) begin
              armed = 1;
              gap = 0;
            end
          end
        end
      end else if (armed) begin
        gap++;
      end
      if (done) begin
        chk("done_latency", dcnt, DLAT);
        chk("handshakes", hs, NOPS);
        chk("busy_at_done", int'(busy), 0);
        chk("queue_drained", q.size(), 0);
        dcnt = -1;
        hs = 0;
      end
      done_prev = done;
    end
  end

  task automatic chk_idle(input string nm);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_valid"}, int'(op_valid), 0);
    chk({nm, "_a"}, int'(op_addr_a), 0);
    chk({nm, "_b"}, int'(op_addr_b), 0);
    chk({nm, "_tw"}, int'(op_tw_addr), 0);
    chk({nm, "_stage"}, int'(op_stage), 0);
    chk({nm, "_last"}, int'(op_last), 0);
  endtask

  task automatic run_fft(input bit rnd);
    int n = 0;
    gen_ops();
    start = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      n++;
      start = (n == 4);
      op_ready = rnd ? ($urandom_range(0, 99) < 65) : 1'b1;
      if (done) break;
      if (n > 2000) begin
        chk("done_timeout", 0, 1);
        break;
      end
    end
    if (!rnd) chk("fft_cycles", n, NOPS + 1 + NL * GAP);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("post_done_busy", int'(busy), 0);
    chk("post_done_valid", int'(op_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("post_done_idle", int'(op_valid), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    op_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("in_reset");
    rst = 1'b0;
    op_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk_idle("idle");
    end

    run_fft(1'b0);
    run_fft(1'b1);

    op_ready = 1'b1;
    gen_ops();
    start = 1'b1;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (op_valid && op_stage == 4'd1) break;
      if (n > 200) begin
        chk("stage1_timeout", 0, 1);
        break;
      end
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_idle("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    chk_idle("after_reset");

    run_fft(1'b1);
    run_fft(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
